datapath_sequencer: RTL

Multicycle control sequencer for the 8-bit datapath. It owns the program counter and steps each instruction through IF, ID, EX, MEM and WB. It issues request/acknowledge handshakes to instruction and data memory and produces the one-cycle strobes that load the instruction register and write the register file. It sits beside the datapath, drives `pc`, and consumes the fetched opcode, the 3-bit immediate and the ALU zero flag.

---
 rtl/datapath_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multicycle IF/ID/EX/MEM/WB control sequencer for the 8-bit datapath.
// Owns the program counter and the retired-instruction counter, runs the instruction/data
// memory req/ack handshakes and emits the IR-load and register-file write strobes.
// Optional memory-ack watchdog: compiled in when SEQ_TIMEOUT_EN is defined.
module datapath_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       sysclk,
  input  logic       sysrst_n,
  input  logic       run,
  input  logic [2:0] inst,
  input  logic [2:0] aux,
  input  logic       alu_zero,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic [7:0] pc,
  output logic       ir_load,
  output logic       reg_we,
  output logic [2:0] stage,
  output logic       busy,
  output logic       halted,
  output logic       fault,
  output logic [7:0] instret
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StIf     = 3'd1,
    StId     = 3'd2,
    StEx     = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalted = 3'd6
  } state_e;

  localparam logic [2:0] OpLd   = 3'b011;
  localparam logic [2:0] OpSt   = 3'b100;
  localparam logic [2:0] OpBrz  = 3'b110;
  localparam logic [2:0] OpHalt = 3'b111;

  state_e     state_q, state_d;
  logic [2:0] op_q, imm_q;
  logic [7:0] pc_q, pc_d, instret_q;
  logic       retire;
  logic       tmo;

  // A zero budget would time out before any ack could be seen.
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("TIMEOUT must be nonzero");
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] wait_q, wait_d;
  logic            fault_q;
  logic            waiting;

  assign waiting = ((state_q == StIf) && !imem_ack) || ((state_q == StMem) && !dmem_ack);
  assign tmo     = waiting && (wait_q == CntW'(TIMEOUT - 1));
  // Restart on every state change so IF and MEM each get a full budget.
  assign wait_d  = ((state_d == state_q) && waiting) ? wait_q + CntW'(1) : '0;
  assign fault   = fault_q;

  // Watchdog counter and sticky fault flag.
  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      if (tmo) fault_q <= 1'b1;
    end
  end
`else
  assign tmo   = 1'b0;
  assign fault = 1'b0;
`endif

  // Instruction completes in this state; pc/instret advance on the edge leaving it.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      StEx:    retire = (op_q == OpBrz);
      StMem:   retire = dmem_ack && (op_q == OpSt);
      StWb:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) state_q <= StIdle;
    else           state_q <= state_d;
  end

  // Next-state logic; run is only consulted in IDLE, HALTED and at retirement.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (run) state_d = StIf;
      StIf: begin
        if (imem_ack)  state_d = StId;
        else if (tmo)  state_d = StHalted;
      end
      StId:   state_d = (op_q == OpHalt) ? StHalted : StEx;
      StEx: begin
        if ((op_q == OpLd) || (op_q == OpSt)) state_d = StMem;
        else if (op_q != OpBrz)               state_d = StWb;
      end
      StMem: begin
        if (dmem_ack)  state_d = StWb;
        else if (tmo)  state_d = StHalted;
      end
      StHalted: if (!run) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (retire) state_d = run ? StIf : StIdle;
  end

  // Program counter: taken BRZ adds the sign-extended immediate, everything else steps by one.
  always_comb begin
    pc_d = pc_q;
    if (retire) begin
      if ((state_q == StEx) && alu_zero) pc_d = pc_q + 8'd1 + {{5{imm_q[2]}}, imm_q};
      else                               pc_d = pc_q + 8'd1;
    end
  end

  // Architectural registers and the latched opcode/immediate.
  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      pc_q      <= 8'h00;
      instret_q <= 8'h00;
      op_q      <= 3'b000;
      imm_q     <= 3'b000;
    end else begin
      pc_q <= pc_d;
      if (retire) instret_q <= instret_q + 8'd1;
      if (ir_load) begin
        op_q  <= inst;
        imm_q <= aux;
      end
    end
  end

  // Handshake requests and strobes; ir_load is the only Mealy output.
  always_comb begin
    imem_req = (state_q == StIf);
    ir_load  = (state_q == StIf) && imem_ack;
    dmem_req = (state_q == StMem);
    dmem_we  = (state_q == StMem) && (op_q == OpSt);
    reg_we   = (state_q == StWb);
    busy     = (state_q != StIdle) && (state_q != StHalted);
    halted   = (state_q == StHalted);
    stage    = state_q;
  end

  assign pc      = pc_q;
  assign instret = instret_q;

endmodule
